// File: rtl/mips_pkg.sv
// Shared store-buffer types: memwrite encodings and the queued store entry.
// Entry fields are sized for the widest supported address and data bus.
package mips_pkg;

    localparam logic [1:0] MW_NONE  = 2'b00;
    localparam logic [1:0] MW_WORD  = 2'b01;
    localparam logic [1:0] MW_DWORD = 2'b10;

    localparam int SB_AW = 64;
    localparam int SB_DW = 64;

    typedef struct packed {
        logic [SB_AW-1:0] adr;
        logic [SB_DW-1:0] data;
        logic [1:0]       size;
    } store_entry_t;

    function automatic logic is_store(input logic [1:0] mw);
        return (mw == MW_WORD) || (mw == MW_DWORD);
    endfunction

endpackage

// File: rtl/store_fwd_lookup.sv
// Combinational load lookup over the queued stores, youngest entry first.
// In: entries, head, count, ld_req/ld_adr/ld_size. Out: fwd_hit, fwd_data, ld_conflict.
module store_fwd_lookup
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int DW    = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH+1)
) (
    input  store_entry_t    entries [DEPTH],
    input  logic [PW-1:0]   head,
    input  logic [CW-1:0]   count,
    input  logic            ld_req,
    input  logic [AW-1:0]   ld_adr,
    input  logic [1:0]      ld_size,
    output logic            fwd_hit,
    output logic [DW-1:0]   fwd_data,
    output logic            ld_conflict
);

    logic          found;
    logic          exact;
    logic [PW-1:0] idx;
    store_entry_t  young;

    // Walk oldest to youngest; the last granule match wins.
    always_comb begin
        found = 1'b0;
        young = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count &&
                entries[idx].adr[AW-1:3] == ld_adr[AW-1:3]) begin
                found = 1'b1;
                young = entries[idx];
            end
        end
    end

    assign exact = found &&
                   young.adr[AW-1:0] == ld_adr &&
                   young.size == ld_size;

    assign fwd_hit     = ld_req && exact;
    assign ld_conflict = ld_req && found && !exact;
    assign fwd_data    = fwd_hit ? young.data[DW-1:0] : '0;

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and memory, with load forwarding.
// Ports: store in (memwrite/dataadr/writedata, stall), load lookup, memory drain handshake, count/empty.
module store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int DW    = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH+1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      memwrite,
    input  logic [AW-1:0]   dataadr,
    input  logic [DW-1:0]   writedata,
    output logic            stall,
    input  logic            ld_req,
    input  logic [AW-1:0]   ld_adr,
    input  logic [1:0]      ld_size,
    output logic            fwd_hit,
    output logic [DW-1:0]   fwd_data,
    output logic            ld_conflict,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [AW-1:0]   mem_adr,
    output logic [DW-1:0]   mem_data,
    output logic [1:0]      mem_size,
    output logic [CW-1:0]   count,
    output logic            empty
);

    store_entry_t  buf_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          st_req;
    logic          enq;
    logic          deq;
    store_entry_t  new_e;
    store_entry_t  head_e;

    assign full   = (count_q == CW'(DEPTH));
    assign st_req = is_store(memwrite);
    // No slot reuse on a full buffer, even when the head drains this cycle.
    assign enq    = st_req && !full;
    assign deq    = mem_valid && mem_ready;
    assign stall  = full && st_req;

    always_comb begin
        new_e      = '0;
        new_e.adr  = SB_AW'(dataadr);
        new_e.size = memwrite;
        if (memwrite == MW_WORD) begin
            new_e.data = SB_DW'(writedata[31:0]);
        end else begin
            new_e.data = SB_DW'(writedata);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + PW'(1);
        end
        if (deq) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) begin
                buf_q[tail_q] <= new_e;
            end
        end
    end

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign mem_valid = !empty;
    assign head_e    = buf_q[head_q];
    // Fields read zero whenever nothing is presented.
    assign mem_adr   = mem_valid ? head_e.adr[AW-1:0]  : '0;
    assign mem_data  = mem_valid ? head_e.data[DW-1:0] : '0;
    assign mem_size  = mem_valid ? head_e.size         : MW_NONE;

    store_fwd_lookup #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_lookup (
        .entries     (buf_q),
        .head        (head_q),
        .count       (count_q),
        .ld_req      (ld_req),
        .ld_adr      (ld_adr),
        .ld_size     (ld_size),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .ld_conflict (ld_conflict)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus random traffic.
// Expected values come from a queue-based model of the buffer.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic [1:0]  memwrite;
    logic [63:0] dataadr;
    logic [63:0] writedata;
    logic        stall;
    logic        ld_req;
    logic [63:0] ld_adr;
    logic [1:0]  ld_size;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic        ld_conflict;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_adr;
    logic [63:0] mem_data;
    logic [1:0]  mem_size;
    logic [2:0]  count;
    logic        empty;

    store_buffer #(.DEPTH(4), .AW(64), .DW(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .stall       (stall),
        .ld_req      (ld_req),
        .ld_adr      (ld_adr),
        .ld_size     (ld_size),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .ld_conflict (ld_conflict),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_adr     (mem_adr),
        .mem_data    (mem_data),
        .mem_size    (mem_size),
        .count       (count),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] adr;
        logic [63:0] data;
        logic [1:0]  size;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] drained[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic st_valid(input logic [1:0] mw);
        return mw == 2'b01 || mw == 2'b10;
    endfunction

    // Apply inputs, let them settle, and compare every output with the model.
    task automatic drive(input logic [1:0] mw, input logic [63:0] a,
                         input logic [63:0] d, input logic lr,
                         input logic [63:0] la, input logic [1:0] ls,
                         input logic rdy);
        ent_t y;
        logic found;
        logic e_hit;
        logic e_conf;
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        ld_req    = lr;
        ld_adr    = la;
        ld_size   = ls;
        mem_ready = rdy;
        #1;
        found = 1'b0;
        y = '{adr: 64'd0, data: 64'd0, size: 2'd0};
        for (int k = mq.size() - 1; k >= 0; k--) begin
            if (!found && mq[k].adr[63:3] == la[63:3]) begin
                found = 1'b1;
                y = mq[k];
            end
        end
        e_hit  = lr && found && y.adr == la && y.size == ls;
        e_conf = lr && found && !e_hit;
        check("count", 64'(count), 64'(mq.size()));
        check("empty", 64'(empty), 64'(mq.size() == 0));
        check("stall", 64'(stall), 64'(mq.size() == 4 && st_valid(mw)));
        check("mem_valid", 64'(mem_valid), 64'(mq.size() != 0));
        check("mem_adr", mem_adr, mq.size() != 0 ? mq[0].adr : 64'd0);
        check("mem_data", mem_data, mq.size() != 0 ? mq[0].data : 64'd0);
        check("mem_size", 64'(mem_size), mq.size() != 0 ? 64'(mq[0].size) : 64'd0);
        check("fwd_hit", 64'(fwd_hit), 64'(e_hit));
        check("ld_conflict", 64'(ld_conflict), 64'(e_conf));
        check("fwd_data", fwd_data, e_hit ? y.data : 64'd0);
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        int pre;
        ent_t e;
        @(posedge clk);
        pre = mq.size();
        if (pre != 0 && mem_ready) begin
            drained.push_back(mq[0].adr);
            void'(mq.pop_front());
        end
        if (st_valid(memwrite) && pre < 4) begin
            e.adr  = dataadr;
            e.data = memwrite == 2'b01 ? {32'd0, writedata[31:0]} : writedata;
            e.size = memwrite;
            mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        drive(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 2'b00, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && mq.size() != 0; i++) begin
            idle(1'b1);
            tick();
        end
        idle(1'b0);
        check("drained_empty", 64'(empty), 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] la;
        logic [1:0]  mw;
        logic [1:0]  ls;
        int          r;
        int          rp;
        clk = 1'b0;
        reset = 1'b0;
        memwrite = 2'b01;
        dataadr = 64'd0;
        writedata = 64'd0;
        ld_req = 1'b0;
        ld_adr = 64'd0;
        ld_size = 2'b00;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_valid", 64'(mem_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_adr", mem_adr, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        drive(2'b10, 64'd100, 64'd7, 1'b0, 64'd0, 2'b00, 1'b0);
        tick();
        drive(2'b00, 64'd0, 64'd0, 1'b1, 64'd100, 2'b10, 1'b0);
        check("p1_valid", 64'(mem_valid), 64'd1);
        check("p1_adr", mem_adr, 64'd100);
        check("p1_data", mem_data, 64'd7);
        check("p1_size", 64'(mem_size), 64'd2);
        check("p1_hit", 64'(fwd_hit), 64'd1);
        check("p1_fwd", fwd_data, 64'd7);
        tick();
        drain();

        drive(2'b10, 64'd320, 64'd10, 1'b0, 64'd0, 2'b00, 1'b0);
        tick();
        drive(2'b10, 64'd320, 64'd4950, 1'b0, 64'd0, 2'b00, 1'b0);
        tick();
        drive(2'b00, 64'd0, 64'd0, 1'b1, 64'd320, 2'b10, 1'b0);
        check("p2_fwd", fwd_data, 64'd4950);
        tick();
        idle(1'b1);
        check("p2_first", mem_data, 64'd10);
        tick();
        idle(1'b1);
        check("p2_second", mem_data, 64'd4950);
        tick();
        idle(1'b0);
        check("p2_empty", 64'(empty), 64'd1);

        drive(2'b01, 64'd80, 64'd1, 1'b0, 64'd0, 2'b00, 1'b0);
        tick();
        drive(2'b00, 64'd0, 64'd0, 1'b1, 64'd80, 2'b10, 1'b0);
        check("p3_conf80", 64'(ld_conflict), 64'd1);
        check("p3_hit80", 64'(fwd_hit), 64'd0);
        drive(2'b00, 64'd0, 64'd0, 1'b1, 64'd84, 2'b01, 1'b0);
        check("p3_conf84", 64'(ld_conflict), 64'd1);
        drive(2'b00, 64'd0, 64'd0, 1'b1, 64'd88, 2'b01, 1'b0);
        check("p3_conf88", 64'(ld_conflict), 64'd0);
        check("p3_hit88", 64'(fwd_hit), 64'd0);
        drive(2'b00, 64'd0, 64'd0, 1'b1, 64'd80, 2'b01, 1'b0);
        check("p3_wordfwd", fwd_data, 64'd1);
        drain();

        drained.delete();
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 64'(i * 8), 64'(i + 100), 1'b0, 64'd0, 2'b00, 1'b0);
            tick();
        end
        drive(2'b11, 64'd200, 64'd9, 1'b0, 64'd0, 2'b00, 1'b0);
        check("p4_full", 64'(count), 64'd4);
        check("p4_rsv_stall", 64'(stall), 64'd0);
        tick();
        drive(2'b10, 64'd32, 64'd104, 1'b0, 64'd0, 2'b00, 1'b1);
        check("p4_stall", 64'(stall), 64'd1);
        tick();
        idle(1'b1);
        check("p4_noenq", 64'(count), 64'd3);
        tick();
        drive(2'b10, 64'd32, 64'd104, 1'b0, 64'd0, 2'b00, 1'b1);
        check("p4_cnt2", 64'(count), 64'd2);
        tick();
        idle(1'b0);
        check("p4_same", 64'(count), 64'd2);
        drain();
        check("p4_n", 64'(drained.size()), 64'd5);
        for (int i = 0; i < 5 && i < drained.size(); i++) begin
            check("p4_order", drained[i], 64'(i * 8));
        end

        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 64'(512 + i * 8), 64'(i), 1'b0, 64'd0, 2'b00, 1'b0);
            tick();
        end
        idle(1'b1);
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 64'(mem_valid), 64'd0);
        check("rst_mid_count", 64'(count), 64'd0);
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
        drive(2'b10, 64'd40, 64'd5, 1'b0, 64'd0, 2'b00, 1'b0);
        tick();
        idle(1'b0);
        check("p6_adr", mem_adr, 64'd40);
        check("p6_data", mem_data, 64'd5);
        tick();
        drain();

        for (int c = 0; c < 1500; c++) begin
            rp = (c / 100) % 3;
            r = $urandom_range(0, 7);
            a = 64'($urandom_range(0, 7)) << 3;
            a = a | (r < 3 ? 64'd0 : r < 6 ? 64'd4 : 64'($urandom_range(0, 7)));
            r = $urandom_range(0, 9);
            mw = r < 4 ? 2'b10 : r < 7 ? 2'b01 : r < 9 ? 2'b00 : 2'b11;
            r = $urandom_range(0, 7);
            la = 64'($urandom_range(0, 7)) << 3;
            la = la | (r < 3 ? 64'd0 : r < 6 ? 64'd4 : 64'($urandom_range(0, 7)));
            ls = 2'($urandom_range(0, 3));
            drive(mw, a, {32'($urandom), 32'($urandom)}, 1'($urandom),
                  la, ls, $urandom_range(0, 3) < rp + 1);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MIPS core's data port and data memory. It accepts the core's stores (`memwrite`, `dataadr`, `writedata`) in one cycle, queues them in a small FIFO, and drains them to memory over a valid/ready handshake. Loads that hit a queued store are forwarded from the buffer. Overlapping loads that cannot be forwarded raise a conflict so the core stalls until the store drains.

## Interface
Parameters:
- `DEPTH`, 4: number of buffered stores (power of two, ≥2)
- `AW`, 64: address width
- `DW`, 64: data width

Ports:
- `clk` in 1: single clock; all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `memwrite` in 2: store request; 00 none, 01 word (32-bit), 10 doubleword, 11 reserved (treated as none)
- `dataadr` in AW: store address
- `writedata` in DW: store data; word stores use [31:0]
- `stall` out 1: buffer full and store presented; core must hold the store
- `ld_req` in 1: load lookup valid
- `ld_adr` in AW: load address
- `ld_size` in 2: load size, same encoding as `memwrite`
- `fwd_hit` out 1: load fully served by the buffer
- `fwd_data` out DW: forwarded data; word zero-extended
- `ld_conflict` out 1: load overlaps a queued store but is not forwardable
- `mem_valid` out 1: head store presented to memory
- `mem_ready` in 1: memory accepts the head store
- `mem_adr` out AW, `mem_data` out DW, `mem_size` out 2: head store fields
- `count` out $clog2(DEPTH+1): occupancy
- `empty` out 1: count == 0

## Operation
- Enqueue on a rising edge when `memwrite` is 01 or 10 and not full. The entry is {adr, data, size}. For word stores, data[63:32] is stored as 0.
- `stall` = full & (`memwrite` ∈ {01,10}). It is combinational from registered full. There is no same-cycle slot reuse: a full buffer stalls even if `mem_ready` is high.
- Dequeue on a rising edge when `mem_valid & mem_ready`. Drain order is strictly FIFO.
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full and empty are derived from `count`.
- Lookup (combinational, qualified by `ld_req`): granule = adr[AW-1:3].
  - Find the youngest entry in the same granule.
  - If its adr == `ld_adr` and its size == `ld_size`: `fwd_hit`=1 and `fwd_data`=entry data.
  - Otherwise, if any entry matches the granule: `ld_conflict`=1.
  - Otherwise both are 0. `fwd_hit` and `ld_conflict` are never both 1.
- The entry being dequeued in the current cycle still participates in the lookup.
- A store being enqueued in the current cycle does not participate.
- Alignment is not checked. Misaligned addresses are queued and drained unchanged.

## Timing
- Enqueue-to-`mem_valid` latency: 1 cycle (no bypass from input to memory port).
- `mem_adr`, `mem_data` and `mem_size` are stable while `mem_valid & !mem_ready`.
- `mem_valid` never drops without a handshake except on reset.
- Back-to-back drain: one store per cycle while `mem_ready`=1.
- Reset (async assert, sync release) sets:
  - `count`=0, pointers=0, `empty`=1
  - `mem_valid`=0, `mem_adr`/`mem_data`/`mem_size`=0
  - `stall`=0, `fwd_hit`=0, `ld_conflict`=0, `fwd_data`=0
- Reset mid-operation discards all pending stores. Memory sees no further handshake for them.
- `mem_ready` with `mem_valid`=0 is ignored.

## Structure
- `mips_pkg` holds:
  - constants MW_NONE=2'b00, MW_WORD=2'b01, MW_DWORD=2'b10
  - typedef `store_entry_t` {adr, data, size}
- Sub-module `store_fwd_lookup` is combinational. It is parameterised by DEPTH and takes the entry array, head pointer and count. It does youngest-first granule match and produces `fwd_hit`, `fwd_data` and `ld_conflict`.
- The FIFO storage and pointers stay in `store_buffer`.

## Test plan
- Store doubleword 7 at 100 with `mem_ready`=0:
  - next cycle `mem_valid`=1, `mem_adr`=100, `mem_data`=7, `mem_size`=10, `count`=1
  - dword lookup at 100 → `fwd_hit`=1, `fwd_data`=7
- Stores 10 then 4950 to 320 (dword), memory held off:
  - lookup at 320 → `fwd_data`=4950
  - release `mem_ready` → memory sees 10 then 4950 in consecutive cycles, then `empty`=1
- Word store 1 at 80:
  - dword load at 80 → `ld_conflict`=1, `fwd_hit`=0
  - word load at 84 → `ld_conflict`=1
  - word load at 88 → both 0
- Four stores (adr 0, 8, 16, 24) with `mem_ready`=0 → `count`=4. A fifth store at 32 → `stall`=1 and it is not enqueued. Enqueue and dequeue in the same cycle at `count`=2 leaves `count`=2. After drain, memory order is 0, 8, 16, 24, 32.
- `memwrite`=11 at 200 → no enqueue, `count` unchanged, `stall`=0.
- Assert `reset` low at `count`=3 mid-handshake → `mem_valid` drops immediately and `count`=0. After release, a store of 5 at 40 appears on the memory port one cycle later.
